// File: rtl/definitions_pkg.sv
// Shared UART definitions: oversampling ratio and the frame parity selection.
package definitions_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_t;

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB-first, optional even/odd
// parity, one or two stop bits, bit timing from a shared oversampling tick.
module uart_tx_cfg
  import definitions_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OS     = OVERSAMPLE
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              s_tick,
  input  logic [DATA_W-1:0] din,
  input  logic              tx_start,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int SW = $clog2(2 * OS);
  localparam int NW = $clog2(DATA_W);

  localparam logic [SW-1:0] S_LAST1 = SW'(OS - 1);
  localparam logic [SW-1:0] S_LAST2 = SW'(2 * OS - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  parity_t           par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_s;
  logic              par_on_s;
  logic [SW-1:0]     stop_last_s;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input parity_t m);
    logic p;
    case (m)
      PAR_ODD: p = ~^d;
      default: p = ^d;
    endcase
    return p;
  endfunction

  assign par_on_s    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign stop_last_s = stop2_q ? S_LAST2 : S_LAST1;

  // Next-state, counters and the line level for the following cycle.
  // tx_d follows the current state, so the line lags the state by one clk.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    tx_d    = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          n_d     = '0;
          shift_d = din;
          data_d  = din;
          par_d   = parity_t'(parity_mode);
          stop2_d = stop2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_LAST1) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (s_q == S_LAST1) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = par_on_s ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_PARITY: begin
        tx_d = parity_bit(data_q, par_q);
        if (s_tick) begin
          if (s_q == S_LAST1) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == stop_last_s) begin
            s_d     = '0;
            done_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        tx_d    = 1'b1;
        s_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns the line to idle-high at once.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = done_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: frames queued at accept, decoded from tx and compared.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk;
  logic       rstN;
  logic       s_tick;
  logic [7:0] din;
  logic       tx_start;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_cfg #(.DATA_W(8), .OS(OS)) dut (
    .clk(clk), .rstN(rstN), .s_tick(s_tick), .din(din), .tx_start(tx_start),
    .parity_mode(parity_mode), .stop2(stop2), .tx(tx), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] pm;
    logic       st2;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  cur;
  exp_t  e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    tick_div = 1;
  int    tick_ph  = 0;
  int    tick_cnt = 0;
  int    exp_ticks = 0;
  int    since_acc = 3;
  int    acc_cnt  = 0;
  bit    b2b_mode = 1'b0;
  bit    prev_done = 1'b0;
  bit    mon_active = 1'b0;
  int    mon_cnt = 0;
  int    mon_idx = 0;
  int    mon_nb  = 0;
  logic [11:0] mon_bits;
  logic [7:0]  word;
  logic        p_on;
  logic        pbit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Oversample tick: one clk wide every tick_div clks.
  always @(posedge clk) begin
    #1;
    if (tick_ph >= tick_div - 1) tick_ph = 0;
    else tick_ph = tick_ph + 1;
    s_tick = (tick_ph == 0);
  end

  // Scoreboard push at accept, tick/handshake timing checks, and tx frame decoder.
  always @(negedge clk) begin
    if (!rstN) begin
      mon_active = 1'b0;
      sb_q.delete();
      since_acc = 3;
      tick_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (b2b_mode && prev_done) check_eq("b2b_accept", 32'(tx_ready && tx_start), 32'd1);
      if (tx_ready && tx_start) begin
        e.d = din; e.pm = parity_mode; e.st2 = stop2;
        sb_q.push_back(e);
        exp_ticks = OS * (1 + 8 + ((parity_mode == 2'b01 || parity_mode == 2'b10) ? 1 : 0)
                          + (stop2 ? 2 : 1));
        tick_cnt  = 0;
        since_acc = 0;
        acc_cnt++;
        check_eq("busy_at_accept", 32'(tx_busy), 32'd0);
      end else begin
        if (since_acc < 3) since_acc++;
        if (since_acc == 1) check_eq("tx_hold_after_accept", 32'(tx), 32'd1);
        if (since_acc == 2) check_eq("tx_low_next_clk", 32'(tx), 32'd0);
        if (!tx_ready && s_tick) tick_cnt++;
        if (tx_done) begin
          check_eq("done_ticks", 32'(tick_cnt), 32'(exp_ticks));
          check_eq("ready_in_done", 32'(tx_ready), 32'd0);
        end
      end
      prev_done = tx_done;

      if (!mon_active) begin
        if (tx == 1'b0) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_frame", 32'd1, 32'd0);
            cur = '0;
          end else begin
            cur = sb_q.pop_front();
          end
          p_on       = (cur.pm == 2'b01) || (cur.pm == 2'b10);
          pbit       = (cur.pm == 2'b10) ? ~^cur.d : ^cur.d;
          mon_nb     = 1 + 8 + (p_on ? 1 : 0) + (cur.st2 ? 2 : 1);
          mon_active = 1'b1;
          mon_cnt    = 0;
          mon_idx    = 0;
          mon_bits   = '0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == (OS * tick_div) / 2 + mon_idx * OS * tick_div) begin
          mon_bits[mon_idx] = tx;
          mon_idx++;
          if (mon_idx == mon_nb) begin
            mon_active = 1'b0;
            for (int i = 0; i < 8; i++) word[i] = mon_bits[1 + i];
            check_eq("start_bit", 32'(mon_bits[0]), 32'd0);
            check_eq("data_word", 32'(word), 32'(cur.d));
            if (p_on) check_eq("parity_bit", 32'(mon_bits[9]), 32'(pbit));
            check_eq("stop_bit1", 32'(mon_bits[mon_nb - (cur.st2 ? 2 : 1)]), 32'd1);
            if (cur.st2) check_eq("stop_bit2", 32'(mon_bits[mon_nb - 1]), 32'd1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    int k;
    k = 0;
    while (!tx_ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 2000) check_eq("ready_timeout", 32'd0, 32'd1);
    din = d; parity_mode = pm; stop2 = s2; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!(tx_ready && !mon_active && sb_q.size() == 0) && k < 3000);
    if (k >= 3000) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    rstN = 1'b0; tx_start = 1'b0; din = '0; parity_mode = 2'b00; stop2 = 1'b0; s_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    // 8N1 plus the reserved parity code behaving as none
    send(8'hA5, 2'b00, 1'b0); wait_idle();
    send(8'hC3, 2'b11, 1'b0); wait_idle();

    // even/odd parity with parity_mode disturbed mid-frame
    send(8'hA5, 2'b01, 1'b0);
    repeat (40) @(posedge clk); #1 parity_mode = 2'b10;
    wait_idle();
    send(8'hA5, 2'b10, 1'b0);
    repeat (40) @(posedge clk); #1 parity_mode = 2'b01; din = 8'h00;
    wait_idle();

    // two stop bits
    send(8'h00, 2'b00, 1'b1); wait_idle();

    // back-to-back with tx_start held high
    b2b_mode = 1'b1;
    k = acc_cnt;
    din = 8'h5A; parity_mode = 2'b01; stop2 = 1'b0; tx_start = 1'b1;
    for (int i = 0; i < 3000 && acc_cnt < k + 1; i++) begin @(posedge clk); #1; end
    din = 8'hC3; parity_mode = 2'b00; stop2 = 1'b1;
    for (int i = 0; i < 3000 && acc_cnt < k + 2; i++) begin @(posedge clk); #1; end
    check_eq("b2b_accepts", 32'(acc_cnt - k), 32'd2);
    tx_start = 1'b0; b2b_mode = 1'b0;
    wait_idle();

    // async reset during data bit 3, then a clean frame
    send(8'hA5, 2'b00, 1'b0);
    repeat (72) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_ready", 32'(tx_ready), 32'd1);
    check_eq("abort_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk); #1;
    send(8'h3C, 2'b00, 1'b0); wait_idle();

    // slow tick, start request while busy must be ignored
    tick_div = 4;
    repeat (4) @(posedge clk); #1;
    send(8'h96, 2'b10, 1'b1);
    repeat (100) @(posedge clk); #1;
    din = 8'hFF; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_idle();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
